// File: rtl/video_scanlines.sv
// CRT scanline emulation for the scandoubled stream: dims every second line,
// optionally blends dimmed lines with the previous line; 2-ce_pix latency on every output.
module video_scanlines #(
   parameter int DWIDTH = 7,
   parameter int LENGTH = 1024
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ce_pix,
   input  logic [1:0]        scanlines,
   input  logic              blend,
   input  logic              hs_in,
   input  logic              vs_in,
   input  logic              hb_in,
   input  logic              vb_in,
   input  logic [DWIDTH:0]   r_in,
   input  logic [DWIDTH:0]   g_in,
   input  logic [DWIDTH:0]   b_in,
   output logic              hs_out,
   output logic              vs_out,
   output logic              hb_out,
   output logic              vb_out,
   output logic [DWIDTH:0]   r_out,
   output logic [DWIDTH:0]   g_out,
   output logic [DWIDTH:0]   b_out
);

   localparam int CW = DWIDTH + 1;
   localparam int AW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
   localparam int XW = $clog2(LENGTH + 1);
   localparam logic [XW-1:0] XMAX = XW'(LENGTH);

   function automatic logic [CW-1:0] avg(input logic [CW-1:0] a, input logic [CW-1:0] b);
      logic [CW:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CW:1];
   endfunction

   function automatic logic [CW-1:0] dim(input logic [CW-1:0] p, input logic [1:0] m);
      case (m)
         2'd1:    return p - (p >> 2);
         2'd2:    return p >> 1;
         2'd3:    return p >> 2;
         default: return p;
      endcase
   endfunction

   logic              hs_d, vs_d, hb_d;
   logic              parity, blend_l;
   logic [1:0]        mode_l;
   logic [XW-1:0]     x, x_cur;
   logic [AW-1:0]     addr;
   logic              line_start, field_start, act_start, x_ok, wr_en;

   logic [3*CW-1:0]   mem [LENGTH];
   logic [3*CW-1:0]   rgb_p1, buf_p1, pix_p2;
   logic              hs_p1, vs_p1, hb_p1, vb_p1, vld_p1;

   // Stage 0: edge detection, column tracking, buffer addressing
   always_comb begin
      line_start  = hs_d & ~hs_in;
      field_start = ~vs_d & vs_in;
      act_start   = hb_d & ~hb_in;
      x_cur       = act_start ? '0 : x;
      x_ok        = (x_cur < XMAX);
      addr        = x_ok ? x_cur[AW-1:0] : '0;
      wr_en       = x_ok & ~hb_in;
   end

   // Stage 1: colour and previous-line pixel; read sees the old contents on a same-address write
   always_ff @(posedge clk_sys) begin
      if (ce_pix) begin
         rgb_p1 <= {r_in, g_in, b_in};
         buf_p1 <= mem[addr];
         if (wr_en) mem[addr] <= {r_in, g_in, b_in};
      end
   end

   // Stage 2: blend, dim, blank
   always_comb begin
      logic [CW-1:0] p;
      pix_p2 = '0;
      for (int i = 0; i < 3; i++) begin
         p = rgb_p1[i*CW +: CW];
         if (parity && blend_l && vld_p1) p = avg(p, buf_p1[i*CW +: CW]);
         if (parity) p = dim(p, mode_l);
         if (hb_p1 || vb_p1) p = '0;
         pix_p2[i*CW +: CW] = p;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         hs_d    <= 1'b0;
         vs_d    <= 1'b0;
         hb_d    <= 1'b0;
         parity  <= 1'b0;
         mode_l  <= 2'd0;
         blend_l <= 1'b0;
         x       <= '0;
         hs_p1   <= 1'b0;
         vs_p1   <= 1'b0;
         hb_p1   <= 1'b1;
         vb_p1   <= 1'b1;
         vld_p1  <= 1'b0;
         hs_out  <= 1'b0;
         vs_out  <= 1'b0;
         hb_out  <= 1'b1;
         vb_out  <= 1'b1;
         r_out   <= '0;
         g_out   <= '0;
         b_out   <= '0;
      end else if (ce_pix) begin
         hs_d <= hs_in;
         vs_d <= vs_in;
         hb_d <= hb_in;
         // a field start wins over the line toggle so the first line of a field is even
         if (field_start)     parity <= 1'b0;
         else if (line_start) parity <= ~parity;
         if (line_start) begin
            mode_l  <= scanlines;
            blend_l <= blend;
         end
         if (!hb_in) x <= (x_cur == XMAX) ? XMAX : x_cur + XW'(1);
         hs_p1  <= hs_in;
         vs_p1  <= vs_in;
         hb_p1  <= hb_in;
         vb_p1  <= vb_in;
         vld_p1 <= x_ok;
         hs_out <= hs_p1;
         vs_out <= vs_p1;
         hb_out <= hb_p1;
         vb_out <= vb_p1;
         {r_out, g_out, b_out} <= pix_p2;
      end
   end

endmodule

// File: doc/video_scanlines.md
Name: video_scanlines

Overview:
- Post-processing stage directly downstream of the scandoubler. It consumes the doubled-rate pixel stream (RGB, syncs, blanks, pixel enable).
- Darkens every second output line to emulate CRT scanlines. Four selectable intensities.
- Optional blend mode averages each dimmed-line pixel with the same-column pixel of the previous line, using an internal single-line buffer.
- Output feeds the video mixer / HDMI path with all signals delay-matched.

Parameters:
DWIDTH, 7, MSB index of each colour component (3 for half-depth builds)
LENGTH, 1024, maximum pixels per line held in the line buffer; buffer address width = ceil(log2(LENGTH))

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous active-high reset
ce_pix  in  1  pixel enable at doubled rate; all state advances only when high
scanlines  in  2  0 off, 1 = 75%, 2 = 50%, 3 = 25% intensity on dimmed lines
blend  in  1  1 = average dimmed-line pixel with previous line before dimming
hs_in  in  1  horizontal sync; falling edge marks line start
vs_in  in  1  vertical sync; rising edge marks field start
hb_in  in  1  horizontal blank
vb_in  in  1  vertical blank
r_in/g_in/b_in  in  DWIDTH+1 each  pixel colour
hs_out/vs_out/hb_out/vb_out  out  1 each  delayed syncs/blanks
r_out/g_out/b_out  out  DWIDTH+1 each  processed colour

Behaviour:
- Reset (clk_sys edge with reset=1; takes priority over ce_pix):
  - r/g/b_out = 0, hs_out = 0, vs_out = 0, hb_out = 1, vb_out = 1.
  - Line parity = 0, column counter x = 0, latched mode/blend = 0, edge-detect registers cleared.
  - Line buffer contents are don't-care. After reset, blend on the first odd line is allowed to use stale data.
- No state changes on cycles with ce_pix=0; outputs hold.
- Latency: exactly 2 ce_pix cycles from input to output for every output (RGB, hs, vs, hb, vb). Syncs and blanks run through a matching 2-stage shift register.
- Edge detection: hs_in, vs_in and hb_in are each registered on ce_pix; edges compare the registered value with the current input.
- Line start (hs_in falling):
  - parity toggles.
  - scanlines and blend are latched into mode_l/blend_l. Mid-line input changes take effect only at the next line start.
- Field start (vs_in rising): parity forced to 0. This overrides a toggle on the same ce_pix, so the first line after vs is even.
- Column counter x:
  - x is cleared on hb_in falling (active video start).
  - x increments on each ce_pix with hb_in=0 and saturates at LENGTH. x = LENGTH means overflow.
- Line buffer: simple dual-port, one write and one synchronous read per ce_pix, both at address x.
  - Write: each active pixel (hb_in=0, x<LENGTH) stores the raw r/g/b_in at x.
  - Read: returns the previous line's value in stage 2. The read precedes the write, i.e. read-during-write returns old data.
- Stage 1: register colour, the x<LENGTH valid flag, and blanks; issue the buffer read.
- Stage 2:
  - p = stage-1 colour.
  - If parity=1, blend_l=1 and valid: p = (p + buf) >> 1 per component. Use a DWIDTH+2-bit sum, floor.
  - If parity=1, apply dim per component:
    - mode 1: p - (p>>2)
    - mode 2: p>>1
    - mode 3: p>>2
    - mode 0: p
  - All arithmetic is floor and never overflows.
  - Even lines pass through unchanged.
- Blanking: if the delayed hb or vb is 1, RGB output is forced to 0 regardless of mode.
- Overflow: pixels at x >= LENGTH are not written, and blending is bypassed for them (dim still applies).

Test Plan:
- Reset mid-line with ce_pix=1 -> next cycle rgb_out=0, hb_out=vb_out=1, hs_out=vs_out=0. After release, first line is even (undimmed).
- scanlines=2, constant input 0xFF, two lines -> even line outputs 0xFF, odd line outputs 0x7F. Output appears 2 ce_pix after input; hs_out/hb_out are delayed identically.
- scanlines=1 with input 0x80, then scanlines=3 with input 0x80, odd line -> 0x60 and 0x20. Changing scanlines from 1 to 3 mid-line -> change takes effect only after the next hs_in falling edge.
- blend=1, scanlines=0: even line pixel 0xC8 at x=5, odd line pixel 0x10 at x=5 -> odd output 0x6C at that column.
- vs_in rises on the same ce_pix as hs_in falls -> parity=0 and the following line is undimmed. ce_pix held low for 10 cycles mid-line -> all outputs frozen.
- LENGTH=16, 20-pixel line with blend=1, scanlines=2 -> pixels 16..19 on the odd line are dimmed only (no blend). hb high -> rgb_out=0.
